// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: feeds two latched operands LSB-first through one
// full-adder cell, keeping the carry in a flip-flop between bits.

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (x & cin) | (y & cin);
endmodule

// Handshake: start is sampled only in IDLE and is otherwise ignored; busy is high
// for the whole RUN state; done pulses for exactly one cycle, and result/cout/ovf
// are valid from that cycle and hold until the next completion or reset.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_co;

  full_adder_cell u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .cin(carry),
    .s  (fa_sum),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= {fa_sum, acc[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB at this bit.
            result <= {fa_sum, acc[WIDTH-1:1]};
            cout   <= fa_co;
            ovf    <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub at WIDTH=8 and WIDTH=13, with both
// instances driven from the same stimulus.

module tb_serial_add_sub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [12:0] a = '0;
  logic [12:0] b = '0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  res8;
  logic [1:0]  st8;
  logic        busy13, done13, cout13, ovf13;
  logic [12:0] res13;
  logic [1:0]  st13;

  int passes = 0;
  int total  = 0;

  logic [7:0]  r8;
  logic        c8, v8;
  int          lat8, n8;
  logic [12:0] r13;
  logic        c13, v13;
  int          lat13, n13;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8),
    .dbg_state(st8)
  );

  serial_add_sub #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy13), .done(done13), .result(res13), .cout(cout13), .ovf(ovf13),
    .dbg_state(st13)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {ovf, cout, result} from integer arithmetic and sign rules.
  function automatic logic [14:0] model(input int w, input int ia, input int ib, input bit is);
    int mask, aa, bb, s, r, c, sa, sb, sr;
    mask = (1 << w) - 1;
    aa   = ia & mask;
    bb   = is ? (~ib & mask) : (ib & mask);
    s    = aa + bb + (is ? 1 : 0);
    r    = s & mask;
    c    = (s >> w) & 1;
    sa   = (aa >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    sr   = (r >> (w - 1)) & 1;
    model = {((sa == sb) && (sr != sa)) ? 1'b1 : 1'b0, c[0], r[12:0]};
  endfunction

  // One operation on both instances; captures outputs at each done pulse.
  task automatic run(input logic [12:0] ia, input logic [12:0] ib, input logic is);
    logic [14:0] e8, e13;
    a = ia; b = ib; sub = is; start = 1'b1;
    step();
    start = 1'b0;
    a = 13'($urandom); b = 13'($urandom); sub = 1'($urandom);
    n8 = 0; n13 = 0; lat8 = -1; lat13 = -1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (done8)  begin n8++;  lat8 = c;  r8 = res8;   c8 = cout8;  v8 = ovf8;  end
      if (done13) begin n13++; lat13 = c; r13 = res13; c13 = cout13; v13 = ovf13; end
    end
    e8  = model(8, int'(ia), int'(ib), is);
    e13 = model(13, int'(ia), int'(ib), is);
    chk("done_count8", 32'(n8), 32'd1);
    chk("latency8", 32'(lat8), 32'd8);
    chk("result8", 32'(r8), 32'(e8[7:0]));
    chk("cout8", 32'(c8), 32'(e8[13]));
    chk("ovf8", 32'(v8), 32'(e8[14]));
    chk("done_count13", 32'(n13), 32'd1);
    chk("latency13", 32'(lat13), 32'd13);
    chk("result13", 32'(r13), 32'(e13[12:0]));
    chk("cout13", 32'(c13), 32'(e13[13]));
    chk("ovf13", 32'(v13), 32'(e13[14]));
  endtask

  initial begin
    int nd;
    int de[$];
    logic [7:0] rr[$];

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_result", 32'(res8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_state", 32'(st8), 32'd0);
    rst = 1'b0;
    step();

    // Add 0x35 + 0x4A with cycle-accurate handshake checks
    a = 13'h35; b = 13'h4A; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_edge0", 32'(busy8), 32'd1);
    chk("done_edge0", 32'(done8), 32'd0);
    for (int e = 1; e <= 7; e++) step();
    chk("busy_edge7", 32'(busy8), 32'd1);
    chk("done_edge7", 32'(done8), 32'd0);
    chk("result_held_run", 32'(res8), 32'd0);
    step();
    chk("done_edge8", 32'(done8), 32'd1);
    chk("busy_edge8", 32'(busy8), 32'd0);
    chk("add_result", 32'(res8), 32'h7F);
    chk("add_cout", 32'(cout8), 32'd0);
    chk("add_ovf", 32'(ovf8), 32'd0);
    step();
    chk("done_edge9", 32'(done8), 32'd0);
    chk("result_hold", 32'(res8), 32'h7F);
    for (int i = 0; i < 6; i++) step();

    // Directed arithmetic corners
    run(13'h0FF, 13'h001, 1'b0);
    chk("wrap_result", 32'(r8), 32'h00); chk("wrap_cout", 32'(c8), 32'd1); chk("wrap_ovf", 32'(v8), 32'd0);
    run(13'h07F, 13'h001, 1'b0);
    chk("sovf_result", 32'(r8), 32'h80); chk("sovf_cout", 32'(c8), 32'd0); chk("sovf_ovf", 32'(v8), 32'd1);
    run(13'h005, 13'h007, 1'b1);
    chk("sub_result", 32'(r8), 32'hFE); chk("sub_cout", 32'(c8), 32'd0); chk("sub_ovf", 32'(v8), 32'd0);
    run(13'h080, 13'h001, 1'b1);
    chk("subovf_result", 32'(r8), 32'h7F); chk("subovf_cout", 32'(c8), 32'd1); chk("subovf_ovf", 32'(v8), 32'd1);

    // Start during RUN ignored; back-to-back start right after done
    a = 13'h10; b = 13'h20; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 13'hFF; b = 13'hFF; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    nd = 0;
    for (int e = 4; e <= 22; e++) begin
      step();
      if (done8) begin nd++; de.push_back(e); rr.push_back(res8); end
      if (e == 9) begin a = 13'h21; b = 13'h03; sub = 1'b0; start = 1'b1; end
      else start = 1'b0;
    end
    chk("b2b_done_count", 32'(nd), 32'd2);
    if (de.size() == 2 && rr.size() == 2) begin
      chk("ignored_done_edge", 32'(de[0]), 32'd8);
      chk("ignored_result", 32'(rr[0]), 32'h30);
      chk("b2b_gap", 32'(de[1] - de[0]), 32'd10);
      chk("b2b_result", 32'(rr[1]), 32'h24);
    end
    for (int i = 0; i < 6; i++) step();

    // Reset mid-run aborts without done
    a = 13'h12; b = 13'h34; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_result", 32'(res8), 32'd0);
    chk("abort_state", 32'(st8), 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run(13'h012, 13'h034, 1'b0);
    chk("after_abort_result", 32'(r8), 32'h46);

    // Random operations on both widths
    for (int i = 0; i < 500; i++)
      run(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
